// File: rtl/sig_chk_pkg.sv
// Shared definitions for the multiplier signature checker and its MISR compactor.
// MISR constants are also used by mult_block's compactor.
package sig_chk_pkg;

  localparam int          SIG_W_DEF     = 16;
  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
  localparam logic [15:0] MISR_SEED_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sig_misr.sv
// One-step MISR: shift left, fold in POLY when the msb falls out, xor in the sample.
// seed_load has priority over en.
module sig_misr
  import sig_chk_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = MISR_SEED_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] misr
);

  logic [SIG_W-1:0] misr_nxt;

  assign misr_nxt = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      misr <= SEED;
    end else if (seed_load) begin
      misr <= SEED;
    end else if (en) begin
      misr <= misr_nxt;
    end
  end

endmodule

// File: rtl/mult_sig_checker.sv
// Signature stream checker: compacts NUM_SAMPLES samples into a MISR and compares with golden.
// Optional idle watchdog is built only when SIG_CHK_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | seed MISR, clear count and result flags
// RUN   | accepting samples (sig_ready=1)
// CHECK | compare MISR with captured golden
// DONE  | result held; start begins a new run
module mult_sig_checker
  import sig_chk_pkg::*;
#(
  parameter int               SIG_W       = SIG_W_DEF,
  parameter int               NUM_SAMPLES = 100,
  parameter logic [SIG_W-1:0] MISR_POLY   = MISR_POLY_DEF,
  parameter logic [SIG_W-1:0] MISR_SEED   = MISR_SEED_DEF,
  parameter int               TIMEOUT_CYC = 64,
  localparam int              CW          = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  input  logic             sig_valid,
  input  logic [SIG_W-1:0] sig_data,
  output logic             sig_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [SIG_W-1:0] misr_out,
  output logic [CW-1:0]    sample_cnt
);

  state_t           state, state_nxt;
  logic [SIG_W-1:0] golden_q;
  logic [SIG_W-1:0] misr;
  logic [CW-1:0]    cnt;
  logic             pass_q;
  logic             accept;
  logic             last;
  logic             wd_expire;

  assign accept = (state == RUN) && sig_valid;
  assign last   = (cnt == CW'(NUM_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (accept && last) begin
          state_nxt = CHECK;
        end else if (wd_expire) begin
          state_nxt = DONE;
        end
      end
      CHECK:   state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      golden_q <= '0;
      cnt      <= '0;
      pass_q   <= 1'b0;
    end else begin
      if (start && ((state == IDLE) || (state == DONE))) begin
        golden_q <= golden;
      end
      if (state == LOAD) begin
        cnt    <= '0;
        pass_q <= 1'b0;
      end else if (accept && (cnt != CW'(NUM_SAMPLES))) begin
        cnt <= cnt + 1'b1;
      end
      if (state == CHECK) begin
        pass_q <= (misr == golden_q);
      end
    end
  end

  sig_misr #(
    .SIG_W (SIG_W),
    .POLY  (MISR_POLY),
    .SEED  (MISR_SEED)
  ) u_misr (
    .clk       (clk),
    .reset     (reset),
    .en        (accept),
    .seed_load (state == LOAD),
    .data      (sig_data),
    .misr      (misr)
  );

`ifdef SIG_CHK_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;

  // Down-counter reloaded on every accepted sample; terminal count on an idle cycle aborts.
  assign wd_expire = (state == RUN) && !sig_valid && (wd_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == LOAD) || accept) begin
        wd_cnt <= WDW'(TIMEOUT_CYC - 1);
      end else if ((state == RUN) && (wd_cnt != '0)) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
      if (state == LOAD) begin
        timeout_q <= 1'b0;
      end else if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  // No watchdog: TIMEOUT_CYC is a positive count, so this is constant 0.
  assign timeout   = (TIMEOUT_CYC < 0);
`endif

  assign sig_ready  = (state == RUN);
  assign busy       = (state == LOAD) || (state == RUN) || (state == CHECK);
  assign done       = (state == DONE);
  assign pass       = pass_q;
  assign misr_out   = misr;
  assign sample_cnt = cnt;

endmodule

// File: tb/tb_mult_sig_checker.sv
// Directed self-checking bench for mult_sig_checker with a queue scoreboard of expected run results.
`timescale 1ns/1ps
module tb_mult_sig_checker;

  localparam int          N    = 100;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;

  typedef struct {
    logic [15:0] misr;
    logic        pass;
    int          cnt;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // single-sample instance
  logic        start1 = 1'b0, valid1 = 1'b0;
  logic [15:0] golden1 = '0, data1 = '0;
  logic        ready1, busy1, done1, pass1, to1;
  logic [15:0] misr1;
  logic [0:0]  cnt1;

  // 100-sample instance
  logic        startN = 1'b0, validN = 1'b0;
  logic [15:0] goldenN = '0, dataN = '0;
  logic        readyN, busyN, doneN, passN, toN;
  logic [15:0] misrN;
  logic [6:0]  cntN;

  mult_sig_checker #(.SIG_W(16), .NUM_SAMPLES(1), .MISR_POLY(POLY), .MISR_SEED(SEED),
                     .TIMEOUT_CYC(64)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .golden(golden1),
    .sig_valid(valid1), .sig_data(data1), .sig_ready(ready1), .busy(busy1),
    .done(done1), .pass(pass1), .timeout(to1), .misr_out(misr1), .sample_cnt(cnt1)
  );

  mult_sig_checker #(.SIG_W(16), .NUM_SAMPLES(N), .MISR_POLY(POLY), .MISR_SEED(SEED),
                     .TIMEOUT_CYC(64)) dutN (
    .clk(clk), .reset(reset), .start(startN), .golden(goldenN),
    .sig_valid(validN), .sig_data(dataN), .sig_ready(readyN), .busy(busyN),
    .done(doneN), .pass(passN), .timeout(toN), .misr_out(misrN), .sample_cnt(cntN)
  );

  int          nchk = 0;
  int          npass = 0;
  logic [15:0] samp [N];
  logic [15:0] model_misr;
  int          idx;

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
    logic [15:0] r;
    r = {m[14:0], 1'b0};
    if (m[15]) r = r ^ POLY;
    return r ^ d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep();
    model_misr = SEED;
    for (int i = 0; i < N; i++) begin
      samp[i]    = 16'($urandom);
      model_misr = misr_step(model_misr, samp[i]);
    end
  endtask

  // Start a run on dutN; golden is changed right after the start cycle to prove it was latched.
  task automatic start_n(input logic [15:0] gold);
    exp_t e;
    e.misr = model_misr;
    e.pass = (gold == model_misr);
    e.cnt  = N;
    sb.push_back(e);
    startN  = 1'b1;
    goldenN = gold;
    tick();
    startN  = 1'b0;
    goldenN = ~gold;
    tick();
    idx = 0;
  endtask

  task automatic feed(input int upto, input bit pulse);
    int cyc = 0;
    bit v;
    bit pulsed = 1'b0;
    while (idx < upto && cyc < 2000) begin
      v      = 1'($urandom_range(0, 1));
      validN = v;
      dataN  = v ? samp[idx] : 16'($urandom);
      if (pulse && idx == 10 && !pulsed) begin
        startN  = 1'b1;
        goldenN = 16'h1234;
        pulsed  = 1'b1;
      end else begin
        startN = 1'b0;
      end
      tick();
      if (v) idx++;
      cyc++;
    end
    validN = 1'b0;
    startN = 1'b0;
    if (idx < upto) check("feed_bound", idx, upto);
  endtask

  task automatic wait_done(input string tag);
    int   k = 0;
    exp_t e;
    while (!doneN && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_done"}, doneN, 1);
    check({tag, "_latency"}, k, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_misr"}, misrN, e.misr);
      check({tag, "_pass"}, passN, e.pass);
      check({tag, "_cnt"}, cntN, e.cnt);
      check({tag, "_timeout"}, toN, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    reset = 1'b0;
    repeat (3) tick();
    check("rst_misr1", misr1, 16'hFFFF);
    check("rst_misrN", misrN, 16'hFFFF);
    check("rst_outs1", {ready1, busy1, done1, pass1, to1, cnt1}, 0);
    check("rst_outsN", {readyN, busyN, doneN, passN, toN, cntN}, 0);
    reset = 1'b1;
    tick();

    // single sample of zero: seed FFFF -> FFFE ^ 1021 = EFDF
    start1 = 1'b1; golden1 = 16'hEFDF; tick();
    start1 = 1'b0; golden1 = 16'h0000; tick();
    check("t1_ready", ready1, 1);
    check("t1_busy", busy1, 1);
    valid1 = 1'b1; data1 = 16'h0000; tick();
    valid1 = 1'b0; data1 = 16'hFFFF;
    check("t1_not_done_yet", done1, 0);
    check("t1_misr_check", misr1, 16'hEFDF);
    tick();
    check("t1_done", done1, 1);
    check("t1_pass", pass1, 1);
    check("t1_misr", misr1, 16'hEFDF);
    check("t1_cnt", cnt1, 1);
    tick(); tick();
    check("t1_sticky", {done1, pass1, busy1, ready1}, 4'b1100);

    // single sample of one -> EFDE, mismatch against golden
    start1 = 1'b1; golden1 = 16'hEFDF; tick();
    start1 = 1'b0; golden1 = 16'h0000;
    check("t2_done_drop", done1, 0);
    tick();
    check("t2_pass_clr", pass1, 0);
    valid1 = 1'b1; data1 = 16'h0001; tick();
    valid1 = 1'b0; tick();
    check("t2_done", done1, 1);
    check("t2_pass", pass1, 0);
    check("t2_misr", misr1, 16'hEFDE);
    check("t2_to", to1, 0);

    // 100 samples with 50% valid
    prep();
    start_n(model_misr);
    feed(N, 1'b0);
    wait_done("t3");

    // start pulsed mid-run must be ignored
    prep();
    start_n(model_misr);
    feed(N, 1'b1);
    wait_done("t4");

    // reset mid-run discards the run
    prep();
    start_n(model_misr);
    feed(40, 1'b0);
    reset = 1'b0;
    tick();
    check("t5_rst_misr", misrN, 16'hFFFF);
    check("t5_rst_outs", {readyN, busyN, doneN, passN, toN, cntN}, 0);
    reset = 1'b1;
    void'(sb.pop_back());
    repeat (5) tick();
    check("t5_no_done", {doneN, busyN}, 0);
    prep();
    start_n(model_misr);
    feed(N, 1'b0);
    wait_done("t5_rerun");

    // long idle gap after 3 samples
    prep();
    start_n(model_misr);
    feed(3, 1'b0);
`ifdef SIG_CHK_TIMEOUT_EN
    k = 0;
    while (!doneN && k < 200) begin
      tick();
      k++;
    end
    check("t6_idle_cycles", k, 64);
    check("t6_done", doneN, 1);
    check("t6_timeout", toN, 1);
    check("t6_pass", passN, 0);
    check("t6_cnt", cntN, 3);
    void'(sb.pop_back());
`else
    k = 0;
    repeat (100) begin
      tick();
      k++;
    end
    check("t6_still_run", {doneN, busyN, readyN, toN}, 4'b0110);
    check("t6_cnt", cntN, 3);
    feed(N, 1'b0);
    wait_done("t6_resume");
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
